// File: rtl/keycode_player.sv
// Scripted keycode source: queues (keycode, hold) commands and replays each as a
// press of max(hold,1) cycles followed by a release gap of max(gap_cycles,1) cycles.
module keycode_player #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_keycode,
    input  logic [HOLD_W-1:0]          cmd_hold,
    input  logic [HOLD_W-1:0]          gap_cycles,
    input  logic                       enable,
    input  logic                       flush,
    output logic [7:0]                 keycode,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t             state, state_nx;
    logic [7:0]         key_nx;
    logic               done_nx;
    logic [HOLD_W-1:0]  hold_cnt, hold_nx;
    logic [HOLD_W-1:0]  gap_cnt, gap_nx;

    logic [7:0]         key_mem  [DEPTH];
    logic [HOLD_W-1:0]  hold_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               full, empty, push, pop;

    // A programmed length of 0 behaves as 1, so the down-counter starts at max(len,1)-1.
    function automatic logic [HOLD_W-1:0] len_to_cnt(input logic [HOLD_W-1:0] len);
        return (len == '0) ? '0 : len - HOLD_W'(1);
    endfunction

    assign full      = (fifo_count == CNT_W'(DEPTH));
    assign empty     = (fifo_count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full && !flush;
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge Clk) begin
        if (push) begin
            key_mem[wr_ptr]  <= cmd_keycode;
            hold_mem[wr_ptr] <= cmd_hold;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        key_nx   = keycode;
        hold_nx  = hold_cnt;
        gap_nx   = gap_cnt;
        done_nx  = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                key_nx = 8'h00;
                if (enable && !empty) begin
                    pop      = 1'b1;
                    key_nx   = key_mem[rd_ptr];
                    hold_nx  = len_to_cnt(hold_mem[rd_ptr]);
                    state_nx = PRESS;
                end
            end
            PRESS: begin
                if (hold_cnt == '0) begin
                    key_nx   = 8'h00;
                    gap_nx   = len_to_cnt(gap_cycles);
                    state_nx = GAP;
                end else begin
                    hold_nx = hold_cnt - HOLD_W'(1);
                end
            end
            GAP: begin
                key_nx = 8'h00;
                if (gap_cnt == '0) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    gap_nx = gap_cnt - HOLD_W'(1);
                end
            end
            default: begin
                key_nx   = 8'h00;
                state_nx = IDLE;
            end
        endcase
        // Abort overrides everything, including a pop decided above.
        if (flush) begin
            state_nx = IDLE;
            key_nx   = 8'h00;
            done_nx  = 1'b0;
            pop      = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            keycode <= 8'h00;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            keycode <= key_nx;
            done    <= done_nx;
        end
    end

    always_ff @(posedge Clk) begin
        hold_cnt <= hold_nx;
        gap_cnt  <= gap_nx;
    end

endmodule

// File: tb/tb_keycode_player.sv
// Directed bench for keycode_player: cycle vectors with hand-computed outputs plus
// hand-written drain and asynchronous-reset sequences.
module tb_keycode_player;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_keycode;
    logic [15:0] cmd_hold;
    logic [15:0] gap_cycles;
    logic        enable;
    logic        flush;
    logic [7:0]  keycode;
    logic        busy;
    logic        done;
    logic [3:0]  fifo_count;

    int tests  = 0;
    int failed = 0;

    keycode_player #(.DEPTH(8), .HOLD_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_keycode(cmd_keycode), .cmd_hold(cmd_hold), .gap_cycles(gap_cycles),
        .enable(enable), .flush(flush), .keycode(keycode), .busy(busy),
        .done(done), .fifo_count(fifo_count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        valid;
        logic [7:0]  key;
        logic [15:0] hold;
        logic [15:0] gap;
        logic        en;
        logic        fl;
        logic [7:0]  ekey;
        logic        ebusy;
        logic        edone;
        logic [3:0]  ecnt;
        logic        erdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [7:0] k, input logic [15:0] h,
                                input logic [15:0] g, input logic e, input logic f,
                                input logic [7:0] ek, input logic eb, input logic ed,
                                input logic [3:0] ec, input logic er);
        vec_t r;
        r.valid = v; r.key = k; r.hold = h; r.gap = g; r.en = e; r.fl = f;
        r.ekey = ek; r.ebusy = eb; r.edone = ed; r.ecnt = ec; r.erdy = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            cmd_valid   = tbl[i].valid;
            cmd_keycode = tbl[i].key;
            cmd_hold    = tbl[i].hold;
            gap_cycles  = tbl[i].gap;
            enable      = tbl[i].en;
            flush       = tbl[i].fl;
            @(posedge Clk);
            #1;
            tests++;
            if ({keycode, busy, done, fifo_count, cmd_ready} !==
                {tbl[i].ekey, tbl[i].ebusy, tbl[i].edone, tbl[i].ecnt, tbl[i].erdy}) begin
                failed++;
                $display("FAIL %s[%0d]: key=%h busy=%b done=%b cnt=%0d rdy=%b, expected key=%h busy=%b done=%b cnt=%0d rdy=%b",
                         tag, i, keycode, busy, done, fifo_count, cmd_ready,
                         tbl[i].ekey, tbl[i].ebusy, tbl[i].edone, tbl[i].ecnt, tbl[i].erdy);
            end
        end
        tbl.delete();
        cmd_valid = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        logic [7:0] seen[$];
        logic [7:0] prev;
        int         dones;
        int         cyc;

        Reset = 1'b1; cmd_valid = 1'b0; cmd_keycode = 8'h00; cmd_hold = 16'd0;
        gap_cycles = 16'd1; enable = 1'b0; flush = 1'b0;
        #22 Reset = 1'b0;
        #1;
        check("reset_state", {keycode, busy, done, fifo_count, cmd_ready}, {8'h00, 1'b0, 1'b0, 4'd0, 1'b1});

        // Single press: hold 3, gap 2
        tbl.push_back(mk(1, 8'h18, 3, 2, 1, 0, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 8'h18, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 8'h18, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 8'h18, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 2, 1, 0, 8'h00, 0, 0, 0, 1));
        apply_table("single");

        // Three queued presses, gap 1: 18,00,00,12,00,00,18
        tbl.push_back(mk(1, 8'h18, 1, 1, 0, 0, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(1, 8'h12, 1, 1, 0, 0, 8'h00, 1, 0, 2, 1));
        tbl.push_back(mk(1, 8'h18, 1, 1, 0, 0, 8'h00, 1, 0, 3, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h18, 1, 0, 2, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 2, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 2, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h12, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 1, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h18, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 0, 1));
        apply_table("b2b");

        // hold=0 and gap=0 each act as one cycle
        tbl.push_back(mk(1, 8'h66, 0, 0, 1, 0, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h66, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 0, 1));
        apply_table("zero_len");

        // Keycode 0x00 command: normal timing, silent output
        tbl.push_back(mk(1, 8'h00, 2, 1, 1, 0, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h00, 0, 0, 0, 1));
        apply_table("delay_cmd");

        // Flush mid-press with a queued entry and a concurrent push
        tbl.push_back(mk(1, 8'h12, 10, 1, 1, 0, 8'h00, 1, 0, 1, 1));
        tbl.push_back(mk(0, 8'h00, 0,  1, 1, 0, 8'h12, 1, 0, 0, 1));
        tbl.push_back(mk(1, 8'h44, 1,  1, 1, 0, 8'h12, 1, 0, 1, 1));
        tbl.push_back(mk(1, 8'h33, 1,  1, 1, 1, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0,  1, 1, 0, 8'h00, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0,  1, 1, 0, 8'h00, 0, 0, 0, 1));
        apply_table("flush");

        // Fill to DEPTH with enable low, drop a 9th, then pop while full with valid high
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(1, 8'(8'h20 + i), 1, 1, 0, 0, 8'h00, 1, 0, 4'(i), (i < 8)));
        tbl.push_back(mk(1, 8'h30, 1, 1, 0, 0, 8'h00, 1, 0, 8, 0));
        tbl.push_back(mk(1, 8'h29, 1, 1, 1, 0, 8'h21, 1, 0, 7, 1));
        apply_table("full");

        seen.delete();
        seen.push_back(keycode);
        prev  = keycode;
        dones = 0;
        cyc   = 0;
        enable = 1'b1;
        while (busy && cyc < 100) begin
            @(posedge Clk);
            #1;
            cyc++;
            if (keycode != 8'h00 && prev == 8'h00) seen.push_back(keycode);
            if (done) dones++;
            prev = keycode;
        end
        check("drain_timeout", {31'd0, busy}, 32'd0);
        check("drain_presses", seen.size(), 8);
        for (int i = 0; i < seen.size() && i < 8; i++)
            check($sformatf("drain_order%0d", i), {24'd0, seen[i]}, 32'h21 + i);
        check("drain_dones", dones, 8);

        // Asynchronous reset in the middle of a long hold
        cmd_valid = 1'b1; cmd_keycode = 8'h55; cmd_hold = 16'd20; gap_cycles = 16'd1;
        @(posedge Clk); #1;
        cmd_valid = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("hold_before_reset", {24'd0, keycode}, 32'h55);
        #2 Reset = 1'b1;
        #1;
        check("async_reset", {keycode, busy, done, fifo_count, cmd_ready}, {8'h00, 1'b0, 1'b0, 4'd0, 1'b1});
        @(posedge Clk);
        #2 Reset = 1'b0;
        @(posedge Clk); #1;
        check("after_reset", {keycode, busy, fifo_count}, {8'h00, 1'b0, 4'd0});

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/keycode_player.md
Name: keycode_player

Overview:
Scripted keycode source that drives the 8-bit keycode bus consumed by the game's key-driven blocks, such as tank selection and movement logic. It serves the AI/demo player and bench regression. Commands (keycode, hold length) are queued in a small FIFO and replayed as press/release waveforms. Every press is followed by a guaranteed release gap (keycode 0x00), so downstream edge-detect flags re-arm between presses.

Parameters:
DEPTH, 8, command FIFO entries; power of two, 2..64
HOLD_W, 16, width of the hold and gap cycle counters

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept; equals !full
cmd_keycode  input  8  keycode to press; 0x00 is a pure delay
cmd_hold  input  HOLD_W  press length in cycles; 0 is treated as 1
gap_cycles  input  HOLD_W  release length in cycles, sampled on entry to GAP; 0 is treated as 1
enable  input  1  permit popping new commands
flush  input  1  synchronous abort and FIFO clear
keycode  output  8  registered keycode bus
busy  output  1  FSM is not IDLE, or FIFO is non-empty
done  output  1  one-cycle pulse at the end of each command's gap
fifo_count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (asynchronous; Clk edges ignored while high):
  - keycode=0x00, done=0, busy=0, fifo_count=0, cmd_ready=1.
  - FSM=IDLE; FIFO pointers cleared.
  - Reset mid-press drops keycode to 0x00 immediately.
- FIFO:
  - Push on a rising edge when cmd_valid & cmd_ready.
  - Simultaneous push and pop allowed; count is unchanged.
  - No push when full, even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, PRESS, GAP. All outputs are registered.
- IDLE:
  - keycode=0x00.
  - If enable & non-empty: pop; keycode<=entry.keycode; hold_cnt<=max(entry.hold,1)-1; go to PRESS.
- PRESS:
  - keycode holds the entry value.
  - If hold_cnt==0: keycode<=0x00; gap_cnt<=max(gap_cycles,1)-1; go to GAP.
  - Else hold_cnt decrements.
  - Net effect: keycode is non-zero for exactly max(hold,1) cycles.
- GAP:
  - keycode=0x00.
  - If gap_cnt==0: done<=1 for one cycle; go to IDLE.
  - Else gap_cnt decrements.
  - Net effect: the release lasts max(gap,1) cycles plus 1 IDLE cycle before the next press.
- Latency:
  - Command accepted at edge E0 on an empty, idle, enabled player: keycode shows the new value after edge E1.
  - Back-to-back commands: 0x00 persists for gap+1 cycles between presses.
- enable:
  - Deassertion does not interrupt PRESS or GAP; it only blocks the pop in IDLE.
  - The FIFO continues to accept commands while enable is low.
- flush (synchronous):
  - Next edge: FIFO empty, FSM=IDLE, keycode=0x00, done=0.
  - flush wins over a push and a pop in the same cycle.
- Keycode 0x00 command: timing is identical to a normal command, but the output stays 0x00 throughout.
- Counters: the full range 2^HOLD_W-1 is supported without wrap. gap_cycles changing during GAP has no effect.

Test Plan:
- Reset, then push {0x18, hold=3}, gap_cycles=2, enable=1 -> keycode 0x18 for exactly 3 cycles starting 1 cycle after acceptance; then 0x00 for 2 cycles; done pulses on the 2nd gap cycle's edge; busy falls after.
- Push {0x18,1},{0x12,1},{0x18,1} back-to-back, gap=1 -> pattern 18,00,00,12,00,00,18; 3 done pulses; fifo_count sequence 1,2,3 then draining to 0.
- enable=0, push DEPTH=8 commands -> cmd_ready=0 at count 8 and a 9th push is dropped; enable=1 -> exactly 8 presses replayed in order.
- Full FIFO with simultaneous valid and pop -> pop occurs and push is rejected; count goes 8->7.
- flush asserted mid-PRESS of {0x12, hold=10} alongside cmd_valid -> keycode 0x00 next cycle, FIFO empty, FSM IDLE, new command not stored.
- Reset asserted asynchronously mid-hold -> keycode 0x00 without a clock edge; hold=0 and gap=0 commands each behave as 1 cycle.
